// File: rtl/ctrl_step_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU selects, FSM states, strobe bundle.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_ctrl_pkg;

    // Opcode field values (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation selects
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // One bit per datapath control strobe
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic mdr_read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic c_out;
        logic ba_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic con_ff_in;
        logic wren;
    } strobes_t;

    function automatic logic is_rtype(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_ROL);
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/ctrl_step_sequencer_if.sv
// Bundle between the sequencer and its surroundings: IR/CON_FF/memory inputs, datapath strobes and status.
// Latency: none (wires only).
// Backpressure: mem_ready is the only throttle; the sequencer drives, the datapath never pushes back otherwise.
interface ctrl_step_sequencer_if #(
    parameter int OPC_W    = 5,
    parameter int ALU_W    = 5,
    parameter int MAX_STEP = 7
);
    localparam int STEP_W = $clog2(MAX_STEP + 1);

    logic              run;
    logic [OPC_W-1:0]  opcode;
    logic              con_ff;
    logic              mem_ready;

    logic              pc_out;
    logic              mar_in;
    logic              inc_pc;
    logic              z_in;
    logic              zlo_out;
    logic              pc_in;
    logic              mdr_read;
    logic              mdr_in;
    logic              mdr_out;
    logic              ir_in;
    logic              y_in;
    logic              c_out;
    logic              ba_out;
    logic              gra;
    logic              grb;
    logic              grc;
    logic              r_in;
    logic              r_out;
    logic              con_ff_in;
    logic              wren;
    logic [ALU_W-1:0]  alu_sel;
    logic [STEP_W-1:0] step;
    logic              busy;
    logic              halted;
    logic              illegal;

    // Side that feeds the sequencer and consumes its strobes
    modport master (
        output run, opcode, con_ff, mem_ready,
        input  pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mdr_read, mdr_in, mdr_out,
               ir_in, y_in, c_out, ba_out, gra, grb, grc, r_in, r_out, con_ff_in, wren,
               alu_sel, step, busy, halted, illegal
    );

    // The sequencer itself
    modport slave (
        input  run, opcode, con_ff, mem_ready,
        output pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mdr_read, mdr_in, mdr_out,
               ir_in, y_in, c_out, ba_out, gra, grb, grc, r_in, r_out, con_ff_in, wren,
               alu_sel, step, busy, halted, illegal
    );
endinterface

// File: rtl/ctrl_step_sequencer_decode.sv
// Combinational map of (opcode, step, con_ff) to the strobe bundle plus end/halt/wait/illegal flags.
// Latency: purely combinational, zero cycles.
// Backpressure: flags which steps are memory-wait steps; the caller decides whether to hold.
module ctrl_step_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W  = 5,
    parameter int ALU_W  = 5,
    parameter int STEP_W = 3
) (
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              con_ff_i,
    output strobes_t          strb_o,
    output logic [ALU_W-1:0]  alu_sel_o,
    output logic              last_o,
    output logic              mem_wait_o,
    output logic              halt_o,
    output logic              illegal_o
);
    logic [4:0]  op;
    logic [31:0] t;

    assign op = 5'(opcode_i);
    assign t  = 32'(step_i);

    // Fetch steps are opcode-independent; from T3 the opcode class selects the microsteps
    always_comb begin
        strb_o     = '0;
        alu_sel_o  = '0;
        last_o     = 1'b0;
        mem_wait_o = 1'b0;
        halt_o     = 1'b0;
        illegal_o  = 1'b0;
        case (t)
            0: begin
                strb_o.pc_out = 1'b1;
                strb_o.mar_in = 1'b1;
                strb_o.inc_pc = 1'b1;
                strb_o.z_in   = 1'b1;
            end
            1: begin
                strb_o.zlo_out  = 1'b1;
                strb_o.pc_in    = 1'b1;
                strb_o.mdr_read = 1'b1;
                strb_o.mdr_in   = 1'b1;
                mem_wait_o      = 1'b1;
            end
            2: begin
                strb_o.mdr_out = 1'b1;
                strb_o.ir_in   = 1'b1;
            end
            default: begin
                if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
                    case (t)
                        3: begin
                            strb_o.grb    = 1'b1;
                            strb_o.ba_out = 1'b1;
                            strb_o.y_in   = 1'b1;
                        end
                        4: begin
                            strb_o.c_out = 1'b1;
                            strb_o.z_in  = 1'b1;
                            alu_sel_o    = ALU_W'(ALU_ADD);
                        end
                        5: begin
                            strb_o.zlo_out = 1'b1;
                            if (op == OP_LDI) begin
                                strb_o.gra  = 1'b1;
                                strb_o.r_in = 1'b1;
                                last_o      = 1'b1;
                            end else begin
                                strb_o.mar_in = 1'b1;
                            end
                        end
                        6: begin
                            if (op == OP_LD) begin
                                strb_o.mdr_read = 1'b1;
                                strb_o.mdr_in   = 1'b1;
                                mem_wait_o      = 1'b1;
                            end else begin
                                strb_o.gra    = 1'b1;
                                strb_o.r_out  = 1'b1;
                                strb_o.mdr_in = 1'b1;
                            end
                        end
                        7: begin
                            last_o = 1'b1;
                            if (op == OP_LD) begin
                                strb_o.mdr_out = 1'b1;
                                strb_o.gra     = 1'b1;
                                strb_o.r_in    = 1'b1;
                            end else begin
                                strb_o.wren = 1'b1;
                                mem_wait_o  = 1'b1;
                            end
                        end
                        default: last_o = 1'b1;
                    endcase
                end else if (is_rtype(op) || is_imm(op)) begin
                    case (t)
                        3: begin
                            strb_o.grb   = 1'b1;
                            strb_o.r_out = 1'b1;
                            strb_o.y_in  = 1'b1;
                        end
                        4: begin
                            strb_o.z_in = 1'b1;
                            if (is_rtype(op)) begin
                                strb_o.grc   = 1'b1;
                                strb_o.r_out = 1'b1;
                                alu_sel_o    = ALU_W'(op);
                            end else begin
                                strb_o.c_out = 1'b1;
                                if (op == OP_ADDI)
                                    alu_sel_o = ALU_W'(ALU_ADD);
                                else if (op == OP_ANDI)
                                    alu_sel_o = ALU_W'(ALU_AND);
                                else
                                    alu_sel_o = ALU_W'(ALU_OR);
                            end
                        end
                        5: begin
                            strb_o.zlo_out = 1'b1;
                            strb_o.gra     = 1'b1;
                            strb_o.r_in    = 1'b1;
                            last_o         = 1'b1;
                        end
                        default: last_o = 1'b1;
                    endcase
                end else if (op == OP_BR) begin
                    case (t)
                        3: begin
                            strb_o.gra       = 1'b1;
                            strb_o.r_out     = 1'b1;
                            strb_o.con_ff_in = 1'b1;
                        end
                        4: begin
                            strb_o.pc_out = 1'b1;
                            strb_o.y_in   = 1'b1;
                        end
                        5: begin
                            strb_o.c_out = 1'b1;
                            strb_o.z_in  = 1'b1;
                            alu_sel_o    = ALU_W'(ALU_ADD);
                        end
                        6: begin
                            // Branch target is only loaded when the condition holds
                            strb_o.zlo_out = con_ff_i;
                            strb_o.pc_in   = con_ff_i;
                            last_o         = 1'b1;
                        end
                        default: last_o = 1'b1;
                    endcase
                end else if (op == OP_NOP) begin
                    last_o = 1'b1;
                end else if (op == OP_HALT) begin
                    halt_o = 1'b1;
                end else begin
                    // Unknown opcode: flag it once in T3 and retire like a nop
                    illegal_o = (t == 32'd3);
                    last_o    = 1'b1;
                end
            end
        endcase
    end
endmodule

// File: rtl/ctrl_step_sequencer.sv
// Hardwired control sequencer: IDLE -> EXEC T0..TMAX_STEP (fetch then per-opcode microsteps) -> IDLE/T0, or HALT.
// Latency: one step per clock; ld/st 8, br 7, ldi/ALU 6, nop 4 cycles. Outputs are Moore, decoded from registered state.
// Backpressure: with CTRL_SEQ_MEM_WAIT_EN defined, memory steps hold until mem_ready=1; otherwise mem_ready is ignored.
module ctrl_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W    = 5,
    parameter int ALU_W    = 5,
    parameter int MAX_STEP = 7
) (
    input logic                 clk,
    input logic                 clr,
    ctrl_step_sequencer_if.slave bus
);
    localparam int                STEP_W    = $clog2(MAX_STEP + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEP);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;

    strobes_t          dec_strb;
    logic [ALU_W-1:0]  dec_alu;
    logic              dec_last;
    logic              dec_mem_wait;
    logic              dec_halt;
    logic              dec_illegal;
    logic              stall;
    logic              end_instr;

    strobes_t          out_strb;
    logic [ALU_W-1:0]  out_alu;
    logic              out_illegal;

    ctrl_step_decode #(
        .OPC_W  (OPC_W),
        .ALU_W  (ALU_W),
        .STEP_W (STEP_W)
    ) u_decode (
        .opcode_i   (bus.opcode),
        .step_i     (step_q),
        .con_ff_i   (bus.con_ff),
        .strb_o     (dec_strb),
        .alu_sel_o  (dec_alu),
        .last_o     (dec_last),
        .mem_wait_o (dec_mem_wait),
        .halt_o     (dec_halt),
        .illegal_o  (dec_illegal)
    );

`ifdef CTRL_SEQ_MEM_WAIT_EN
    assign stall = dec_mem_wait & ~bus.mem_ready;
`else
    logic unused_mem;
    assign unused_mem = bus.mem_ready ^ dec_mem_wait;
    assign stall      = 1'b0;
`endif

    // The last counter value always retires the instruction, whatever the opcode table says
    assign end_instr = dec_last | (step_q == STEP_LAST);

    // State and step registers; clr clears them immediately, even mid-step or mid-stall
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next state: start on run, advance unless stalled, retire to T0 or IDLE, latch into HALT
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_EXEC;
                    step_d  = '0;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    step_d = step_q;
                end else if (dec_halt) begin
                    state_d = ST_HALT;
                    step_d  = '0;
                end else if (end_instr) begin
                    state_d = bus.run ? ST_EXEC : ST_IDLE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
                step_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Outputs: decoded strobes only while executing, everything quiet in IDLE and HALT
    always_comb begin
        out_strb    = '0;
        out_alu     = '0;
        out_illegal = 1'b0;
        if (state_q == ST_EXEC) begin
            out_strb    = dec_strb;
            out_alu     = dec_alu;
            out_illegal = dec_illegal;
        end
    end

    assign bus.pc_out    = out_strb.pc_out;
    assign bus.mar_in    = out_strb.mar_in;
    assign bus.inc_pc    = out_strb.inc_pc;
    assign bus.z_in      = out_strb.z_in;
    assign bus.zlo_out   = out_strb.zlo_out;
    assign bus.pc_in     = out_strb.pc_in;
    assign bus.mdr_read  = out_strb.mdr_read;
    assign bus.mdr_in    = out_strb.mdr_in;
    assign bus.mdr_out   = out_strb.mdr_out;
    assign bus.ir_in     = out_strb.ir_in;
    assign bus.y_in      = out_strb.y_in;
    assign bus.c_out     = out_strb.c_out;
    assign bus.ba_out    = out_strb.ba_out;
    assign bus.gra       = out_strb.gra;
    assign bus.grb       = out_strb.grb;
    assign bus.grc       = out_strb.grc;
    assign bus.r_in      = out_strb.r_in;
    assign bus.r_out     = out_strb.r_out;
    assign bus.con_ff_in = out_strb.con_ff_in;
    assign bus.wren      = out_strb.wren;
    assign bus.alu_sel   = out_alu;
    assign bus.step      = step_q;
    assign bus.busy      = (state_q == ST_EXEC);
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.illegal   = out_illegal;
endmodule

// File: doc/ctrl_step_sequencer.md
# ctrl_step_sequencer

Parametrised hardwired control sequencer for the 32-bit CPU datapath. It replaces the hand-driven T0–T7 signal sequences with a clocked state machine. It fetches and decodes the opcode held in IR, then steps through per-class microsteps, driving the datapath control strobes (PCout, MARin, Zin, Gra/Grb/Grc, Rin/Rout, BAout, Cout, MDRread, wren, ALU select). It sits between IR/CON_FF and `CPU_Datapath`.

## Interface
- `OPC_W`, 5: opcode width (IR[31:27]).
- `ALU_W`, 5: ALU select width.
- `MAX_STEP`, 7: last step index; step counter width is clog2(MAX_STEP+1).
- `clk` in 1: clock; all state changes on rising edge.
- `clr` in 1: reset. Asynchronous, active-high.
- `run` in 1: permit instruction start.
- `opcode` in OPC_W: IR opcode field, sampled in T3 and later.
- `con_ff` in 1: branch condition from CON_FF.
- `mem_ready` in 1: memory read/write complete.
- `pc_out`, `mar_in`, `inc_pc`, `z_in`, `zlo_out`, `pc_in`, `mdr_read`, `mdr_in`, `mdr_out`, `ir_in`, `y_in`, `c_out`, `ba_out`, `gra`, `grb`, `grc`, `r_in`, `r_out`, `con_ff_in`, `wren` out 1: datapath strobes.
- `alu_sel` out ALU_W: ALU operation.
- `step` out clog2(MAX_STEP+1): current T index.
- `busy`, `halted`, `illegal` out 1: status.

## Operation
- States: IDLE, EXEC (with step counter T0..TMAX_STEP), HALT.
- IDLE with `run`=1 → EXEC T0.
- Fetch sequence:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlo_out, pc_in, mdr_read, mdr_in.
  - T2: mdr_out, ir_in.
- Execute sequence, T3 onward, by opcode:
  - ld (00000): T3 grb, ba_out, y_in. T4 c_out, z_in, alu_sel=ADD. T5 zlo_out, mar_in. T6 mdr_read, mdr_in. T7 mdr_out, gra, r_in.
  - ldi (00001): T3 and T4 as ld. T5 zlo_out, gra, r_in. End.
  - st (00010): T3–T5 as ld. T6 gra, r_out, mdr_in. T7 wren.
  - R-type ALU (00011–01011): T3 grb, r_out, y_in. T4 grc, r_out, z_in, alu_sel=opcode. T5 zlo_out, gra, r_in. End.
  - Immediate ALU (01100 addi, 01101 andi, 01110 ori): as R-type, with c_out in place of grc/r_out in T4. alu_sel = ADD / AND / OR.
  - br (10010): T3 gra, r_out, con_ff_in. T4 pc_out, y_in. T5 c_out, z_in, alu_sel=ADD. T6 zlo_out, pc_in only if con_ff=1, otherwise no strobes. End.
  - nop (11010): end at T3 with no strobes.
  - halt (11011): T3 → HALT. Only `clr` exits HALT.
  - Any other opcode: `illegal` pulses high for 1 cycle in T3. Behaves as nop.
- End of instruction: next state is T0 if `run`=1, else IDLE.
- Dropping `run` mid-instruction never aborts; the instruction completes.
- Memory-wait steps (T1 fetch, ld T6, st T7): with stall enabled, the step holds and re-asserts its strobes until `mem_ready`=1. It advances on the edge where `mem_ready` is sampled 1.
- Step counter never exceeds MAX_STEP. Reaching MAX_STEP always ends the instruction.

## Timing
- Moore outputs decode from registered state/step. They are valid the whole cycle and take effect on the datapath at the next rising edge.
- One step per clock; no wait.
- Instruction latency:
  - ld/st: 8 cycles.
  - ldi, ALU, nop: 6 / 6 / 4 cycles.
  - br: 7 cycles.
  - Memory-wait steps add 1 cycle per `mem_ready`=0 cycle.
- `busy`=1 in EXEC. `halted`=1 in HALT.
- Reset: state IDLE, step 0, every strobe 0, alu_sel 0, busy/halted/illegal 0. Reset takes effect immediately on `clr`, including mid-step or mid-stall.
- `clr` and `run` both high: reset wins. The first T0 comes one clock after `clr` falls, with `run`=1.

## Configuration
- `CTRL_SEQ_MEM_WAIT_EN` defined: memory-wait stalls on `mem_ready` as above.
- Undefined: `mem_ready` is ignored, every step is exactly one cycle, and latencies are fixed.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode localparams (LD, LDI, ST, ADD…ROL, ADDI, ANDI, ORI, BR, NOP, HALT);
  - ALU select constants (ADD=00011, AND=00101, OR=00110);
  - state enum.
- One sub-module, `ctrl_step_decode`: combinational map of (opcode, step, con_ff) to strobe bundle and last-step flag. The top holds state, counter and stall logic.

## Test plan
- Reset, then `run`=1, IR opcode 00001 (ldi): T0 pc_out/mar_in/inc_pc/z_in, and T5 zlo_out/gra/r_in. Next T0 arrives 6 cycles after the first.
- add (00011): T4 alu_sel=00011 with grc/r_out. addi (01100): T4 c_out=1, grc=0.
- br with con_ff=1: T6 pc_in=1. Same with con_ff=0: T6 all strobes 0, then T0.
- `CTRL_SEQ_MEM_WAIT_EN`, ld, mem_ready low 3 cycles at T6: T6 strobes held 4 cycles. Total 11 cycles.
- halt (11011): halted=1 and stays with run=1. `clr` pulse mid-HALT returns to IDLE with all outputs 0.
- Opcode 11111: illegal pulses for 1 cycle, instruction ends at T3. `clr` asserted during T4 of ld: outputs 0 asynchronously.
